kernel_loader_mc: RTL
=====================

Name: kernel_loader_mc

Overview:
Parametrised multi-channel kernel loader. Streams K×K×C kernel weights from the weight BRAM into the per-channel kernel register files ahead of a convolution pass. Handles BRAM read latency with an internal valid pipeline and supports runtime kernel size and channel count. Provides start/busy/done handshake, abort, and configuration-error reporting.

Parameters:
BRAM_ADDR_WIDTH, 10, weight BRAM address width
WEIGHT_WIDTH, 8, weight word width
MAX_ELEMS, 25, max elements per channel kernel (5×5)
MAX_CH, 4, max channels per load
ELEM_ADDR_WIDTH, 5, kernel register address width, ≥ clog2(MAX_ELEMS)
CH_WIDTH, 2, channel index width, ≥ clog2(MAX_CH)
READ_LATENCY, 1, BRAM read latency in cycles, 1..4

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  start request, sampled in IDLE only
i_abort  in  1  abort current load
i_kernel_size  in  6  elements per channel, legal 1..MAX_ELEMS
i_num_channels  in  CH_WIDTH+1  channel count, legal 1..MAX_CH
i_base_addr  in  BRAM_ADDR_WIDTH  BRAM address of channel 0, element 0
o_bram_rd_en  out  1  BRAM read strobe
o_bram_addr  out  BRAM_ADDR_WIDTH  BRAM read address
i_bram_rdata  in  WEIGHT_WIDTH  BRAM read data, valid READ_LATENCY cycles after strobe
o_wr_en  out  1  kernel register write enable
o_wr_ch  out  CH_WIDTH  destination channel
o_wr_addr  out  ELEM_ADDR_WIDTH  destination element index
o_wr_data  out  WEIGHT_WIDTH  weight data
o_busy  out  1  high from start acceptance until done/abort
o_done  out  1  one-cycle completion pulse
o_err  out  1  one-cycle pulse on illegal configuration, coincident with o_done

Behaviour:
- Reset (async, i_rst_n low): state IDLE; all outputs 0; counters and valid pipeline cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on i_start, latch size, channels, base. If size==0, size>MAX_ELEMS, channels==0, or channels>MAX_CH, go to DONE with error flag set; no reads. Otherwise go to ISSUE, o_busy=1.
- ISSUE: one read per cycle, o_bram_rd_en=1. Address = base + c*size + e, computed incrementally, modulo 2^BRAM_ADDR_WIDTH (wrap permitted, not an error). Element counter e runs 0..size-1, then resets while channel counter c increments. After the read of (c=channels-1, e=size-1), go to DRAIN.
- Valid pipeline: depth READ_LATENCY carries {valid, c, e}. Its output drives o_wr_en/o_wr_ch/o_wr_addr; o_wr_data = i_bram_rdata in the same cycle. The write for a read issued at cycle t occurs at t+READ_LATENCY.
- DRAIN: o_bram_rd_en=0; when the pipeline is empty (last write done), go to DONE.
- DONE: o_done=1 for one cycle (o_err=1 if error flag); o_busy=0; go to IDLE. Total writes = size*channels; first write READ_LATENCY cycles after the first read.
- i_start while not IDLE: ignored.
- i_abort (any non-IDLE state): next cycle IDLE; pipeline valids cleared, so no further o_wr_en; no o_done. i_abort has priority over i_start in IDLE; a simultaneous start is not accepted.
- Reset mid-load: immediate return to reset values; partial register-file contents are undefined to consumers.

Optional Feature:
KERNEL_BIAS_LOAD_EN: adds state BIAS between ISSUE and DRAIN, plus ports o_bias_wr_en (1), o_bias_ch (CH_WIDTH), o_bias_data (WEIGHT_WIDTH). BIAS issues one read per channel at address base + size*channels + c. Data returns through the same pipeline (tagged as bias) and drives the bias ports; o_wr_en stays 0 for these. Undefined: no BIAS state, no bias ports, and behaviour is exactly as above.

Test Plan:
- size=9, ch=1, base=0x010, LAT=1: reads 0x010..0x018 in 9 consecutive cycles; writes addr 0..8 ch0 with matching data; o_done 1 cycle after last write; o_err=0.
- size=25, ch=4, base=0x100, LAT=3: 100 reads to 0x100..0x163; ch2 e0 reads 0x132; writes lag reads by exactly 3 cycles; o_busy high throughout.
- base=0x3FE, size=4, ch=1: addresses 0x3FE, 0x3FF, 0x000, 0x001; 4 writes; no error.
- size=0 or ch=5 (MAX_CH=4): no o_bram_rd_en; o_done and o_err pulse together 1 cycle after start.
- Abort on the 5th ISSUE cycle of a 9×2 load: no o_wr_en from the cycle after abort; no o_done; new start with size=4 completes normally. Second i_start mid-load has no effect.
- KERNEL_BIAS_LOAD_EN, size=9, ch=2, base=0: 18 weight writes, then bias reads at 0x012 and 0x013 drive o_bias_wr_en for ch0 and ch1; then o_done.

Source files
------------

// File: rtl/kernel_loader_mc.sv
// Streams K*K*C kernel weights from the weight BRAM into per-channel kernel register files.
// Define KERNEL_BIAS_LOAD_EN to also fetch one bias word per channel after the weights.
module kernel_loader_mc #(
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int WEIGHT_WIDTH    = 8,
  parameter int MAX_ELEMS       = 25,
  parameter int MAX_CH          = 4,
  parameter int ELEM_ADDR_WIDTH = 5,
  parameter int CH_WIDTH        = 2,
  parameter int READ_LATENCY    = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [5:0]                 i_kernel_size,
  input  logic [CH_WIDTH:0]          i_num_channels,
  input  logic [BRAM_ADDR_WIDTH-1:0] i_base_addr,
  output logic                       o_bram_rd_en,
  output logic [BRAM_ADDR_WIDTH-1:0] o_bram_addr,
  input  logic [WEIGHT_WIDTH-1:0]    i_bram_rdata,
  output logic                       o_wr_en,
  output logic [CH_WIDTH-1:0]        o_wr_ch,
  output logic [ELEM_ADDR_WIDTH-1:0] o_wr_addr,
  output logic [WEIGHT_WIDTH-1:0]    o_wr_data,
`ifdef KERNEL_BIAS_LOAD_EN
  output logic                       o_bias_wr_en,
  output logic [CH_WIDTH-1:0]        o_bias_ch,
  output logic [WEIGHT_WIDTH-1:0]    o_bias_data,
`endif
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err
);

  localparam logic [5:0]                 MAX_SIZE  = 6'(MAX_ELEMS);
  localparam logic [CH_WIDTH:0]          MAX_CHAN  = (CH_WIDTH+1)'(MAX_CH);
  localparam logic [CH_WIDTH:0]          ONE_CHAN  = (CH_WIDTH+1)'(1);
  localparam logic [CH_WIDTH-1:0]        CH_INC    = CH_WIDTH'(1);
  localparam logic [ELEM_ADDR_WIDTH-1:0] ELEM_INC  = ELEM_ADDR_WIDTH'(1);
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_INC  = BRAM_ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
`ifdef KERNEL_BIAS_LOAD_EN
    S_BIAS,
`endif
    S_DONE
  } state_t;

  state_t                     r_state;
  state_t                     w_nextState;
  logic [5:0]                 r_size;
  logic [CH_WIDTH:0]          r_chans;
  logic                       r_err;
  logic [ELEM_ADDR_WIDTH-1:0] r_elem;
  logic [CH_WIDTH-1:0]        r_ch;
  logic [BRAM_ADDR_WIDTH-1:0] r_addr;

  logic [READ_LATENCY-1:0]    r_pVld;
  logic [CH_WIDTH-1:0]        r_pCh   [READ_LATENCY];
  logic [ELEM_ADDR_WIDTH-1:0] r_pElem [READ_LATENCY];
`ifdef KERNEL_BIAS_LOAD_EN
  logic [READ_LATENCY-1:0]    r_pBias;
`endif

  logic w_accept;
  logic w_cfgBad;
  logic w_elemLast;
  logic w_chLast;
  logic w_issuing;
  logic w_pipeTail;

  assign w_accept   = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_cfgBad   = (i_kernel_size == 6'd0) || (i_kernel_size > MAX_SIZE) ||
                      (i_num_channels == '0) || (i_num_channels > MAX_CHAN);
  assign w_elemLast = (6'(r_elem) == (r_size - 6'd1));
  assign w_chLast   = ((CH_WIDTH+1)'(r_ch) == (r_chans - ONE_CHAN));
`ifdef KERNEL_BIAS_LOAD_EN
  assign w_issuing  = (r_state == S_ISSUE) || (r_state == S_BIAS);
`else
  assign w_issuing  = (r_state == S_ISSUE);
`endif

  // Leaving DRAIN when only the final stage is occupied puts o_done right after the last write.
  always_comb begin
    w_pipeTail = 1'b0;
    for (int i = 0; i < READ_LATENCY - 1; i++) begin
      w_pipeTail = w_pipeTail | r_pVld[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_nextState = w_cfgBad ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (i_abort) w_nextState = S_IDLE;
`ifdef KERNEL_BIAS_LOAD_EN
        else if (w_elemLast && w_chLast) w_nextState = S_BIAS;
      end
      S_BIAS: begin
        if (i_abort) w_nextState = S_IDLE;
        else if (w_chLast) w_nextState = S_DRAIN;
`else
        else if (w_elemLast && w_chLast) w_nextState = S_DRAIN;
`endif
      end
      S_DRAIN: begin
        if (i_abort) w_nextState = S_IDLE;
        else if (!w_pipeTail) w_nextState = S_DONE;
      end
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    o_bram_rd_en = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_err        = 1'b0;
    case (r_state)
      S_ISSUE: begin
        o_bram_rd_en = 1'b1;
        o_busy       = 1'b1;
      end
`ifdef KERNEL_BIAS_LOAD_EN
      S_BIAS: begin
        o_bram_rd_en = 1'b1;
        o_busy       = 1'b1;
      end
`endif
      S_DRAIN: o_busy = 1'b1;
      S_DONE: begin
        o_done = 1'b1;
        o_err  = r_err;
      end
      default: ;
    endcase
  end

  // Address advances by one per read; bias words sit directly after the last weight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_size  <= '0;
      r_chans <= '0;
      r_err   <= 1'b0;
      r_elem  <= '0;
      r_ch    <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_size  <= i_kernel_size;
            r_chans <= i_num_channels;
            r_err   <= w_cfgBad;
            r_addr  <= i_base_addr;
            r_elem  <= '0;
            r_ch    <= '0;
          end
        end
        S_ISSUE: begin
          r_addr <= r_addr + ADDR_INC;
          if (w_elemLast) begin
            r_elem <= '0;
            r_ch   <= w_chLast ? '0 : r_ch + CH_INC;
          end else begin
            r_elem <= r_elem + ELEM_INC;
          end
        end
`ifdef KERNEL_BIAS_LOAD_EN
        S_BIAS: begin
          r_addr <= r_addr + ADDR_INC;
          r_ch   <= w_chLast ? '0 : r_ch + CH_INC;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pVld <= '0;
`ifdef KERNEL_BIAS_LOAD_EN
      r_pBias <= '0;
`endif
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pCh[i]   <= '0;
        r_pElem[i] <= '0;
      end
    end else begin
      if (i_abort && (r_state != S_IDLE)) begin
        r_pVld <= '0;
      end else begin
        r_pVld[0] <= w_issuing;
        for (int i = 1; i < READ_LATENCY; i++) r_pVld[i] <= r_pVld[i-1];
      end
      r_pCh[0]   <= r_ch;
      r_pElem[0] <= r_elem;
`ifdef KERNEL_BIAS_LOAD_EN
      r_pBias[0] <= (r_state == S_BIAS);
      for (int i = 1; i < READ_LATENCY; i++) r_pBias[i] <= r_pBias[i-1];
`endif
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pCh[i]   <= r_pCh[i-1];
        r_pElem[i] <= r_pElem[i-1];
      end
    end
  end

  assign o_bram_addr = r_addr;
  assign o_wr_ch     = r_pCh[READ_LATENCY-1];
  assign o_wr_addr   = r_pElem[READ_LATENCY-1];
`ifdef KERNEL_BIAS_LOAD_EN
  assign o_wr_en      = r_pVld[READ_LATENCY-1] && !r_pBias[READ_LATENCY-1];
  assign o_bias_wr_en = r_pVld[READ_LATENCY-1] && r_pBias[READ_LATENCY-1];
  assign o_bias_ch    = r_pCh[READ_LATENCY-1];
  assign o_bias_data  = o_bias_wr_en ? i_bram_rdata : '0;
`else
  assign o_wr_en      = r_pVld[READ_LATENCY-1];
`endif
  assign o_wr_data   = o_wr_en ? i_bram_rdata : '0;

endmodule
